// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide sequencer.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            busy;

    modport master (
        output flush, req_valid, req_funct3, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data, busy
    );

    modport slave (
        input  flush, req_valid, req_funct3, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, busy
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring
// divide on magnitudes, XLEN iterations. Optional MULDIV_EARLY_OUT_EN skips
// the iterations for zero operands.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    localparam int CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_count;
    logic                r_resp_valid;
    logic [XLEN-1:0]     r_resp_data;

    logic [2:0]          r_f3;
    logic                r_sa;
    logic                r_sb;
    logic                r_b_zero;
    logic [XLEN-1:0]     r_mcand;
    logic [2*XLEN-1:0]   r_acc;

    function automatic logic [XLEN-1:0] f_cond_neg(input logic neg, input logic [XLEN-1:0] v);
        return neg ? ((~v) + XLEN'(1)) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] f_cond_neg_wide(input logic neg, input logic [2*XLEN-1:0] v);
        return neg ? ((~v) + (2*XLEN)'(1)) : v;
    endfunction

    logic w_accept;
    logic w_is_div_in;
    logic w_sa_in;
    logic w_sb_in;
    logic w_b_zero_in;

    assign w_accept    = bus.req_valid & (r_state == IDLE) & ~bus.flush;
    assign w_is_div_in = bus.req_funct3[2];
    // MUL low half is sign-agnostic, so it is run as unsigned.
    assign w_sa_in     = bus.req_a[XLEN-1] &
                         (w_is_div_in ? ~bus.req_funct3[0]
                                      : ((bus.req_funct3[1:0] == 2'b01) || (bus.req_funct3[1:0] == 2'b10)));
    assign w_sb_in     = bus.req_b[XLEN-1] &
                         (w_is_div_in ? ~bus.req_funct3[0] : (bus.req_funct3[1:0] == 2'b01));
    assign w_b_zero_in = (bus.req_b == '0);

    logic w_early;
    logic [XLEN-1:0] w_early_data;

`ifdef MULDIV_EARLY_OUT_EN
    assign w_early = w_accept & (w_b_zero_in | (~w_is_div_in & (bus.req_a == '0)));
    always_comb begin
        w_early_data = '0;
        if (w_is_div_in)
            w_early_data = bus.req_funct3[1] ? bus.req_a : '1;
    end
`else
    assign w_early      = 1'b0;
    assign w_early_data = '0;
`endif

    // Multiply step: conditionally add multiplicand to the upper half, shift right.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_next;
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, {XLEN{r_acc[0]}} & r_mcand};
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide step: shift {rem, quot} left, trial-subtract, restore on borrow.
    logic [XLEN:0]     w_rem_sh;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub;
    logic [2*XLEN-1:0] w_div_next;
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_ge   = (w_rem_sh >= {1'b0, r_mcand});
    assign w_div_sub  = w_rem_sh[XLEN-1:0] - r_mcand;
    assign w_div_next = {(w_div_ge ? w_div_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_div_ge};

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_data;
    assign w_prod = f_cond_neg_wide(r_sa ^ r_sb, r_acc);
    // b_zero keeps a divide-by-zero quotient at all ones regardless of signs.
    assign w_quot = f_cond_neg((r_sa ^ r_sb) & ~r_b_zero, r_acc[XLEN-1:0]);
    assign w_rem  = f_cond_neg(r_sa, r_acc[2*XLEN-1:XLEN]);

    always_comb begin
        w_fix_data = w_prod[2*XLEN-1:XLEN];
        if (r_f3[2])
            w_fix_data = r_f3[1] ? w_rem : w_quot;
        else if (r_f3[1:0] == 2'b00)
            w_fix_data = w_prod[XLEN-1:0];
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_state_next = w_early ? DONE : CALC;
            CALC: if (r_count == CNT_W'(XLEN-1)) w_state_next = FIX;
            FIX:  w_state_next = DONE;
            DONE: if (bus.resp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (bus.flush)
            w_state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else if ((r_state == CALC) && !bus.flush)
            r_count <= r_count + CNT_W'(1);
        else
            r_count <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= (w_state_next == DONE);
            if ((r_state == FIX) && !bus.flush)
                r_resp_data <= w_fix_data;
            else if (w_early)
                r_resp_data <= w_early_data;
        end
    end

    // Operand datapath: loaded at accept, stepped each CALC cycle.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_f3     <= bus.req_funct3;
            r_sa     <= w_sa_in;
            r_sb     <= w_sb_in;
            r_b_zero <= w_b_zero_in;
            r_mcand  <= f_cond_neg(w_sb_in, bus.req_b);
            r_acc    <= {{XLEN{1'b0}}, f_cond_neg(w_sa_in, bus.req_a)};
        end else if (r_state == CALC) begin
            r_acc <= r_f3[2] ? w_div_next : w_mul_next;
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
endmodule
